vxc_add_sequencer: RTL and testbench

VXC_ADD_SEQUENCER -- requirements
Module: vxc_add_sequencer

---
 rtl/vxc_pkg.sv | 19 +
 rtl/vxc_valid_pipe.sv | 44 ++++
 rtl/vxc_add_sequencer.sv | 118 +++++++++++
 tb/tb_vxc_add_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vxc_pkg.sv
// Shared constants and FSM encoding for the vector complex add/subtract unit.
// Used by both the datapath and its sequencer so lane count and latency agree.
package vxc_pkg;

  localparam int VXC_NI            = 8;
  localparam int VXC_ELEMENT_WIDTH = 64;
  localparam int VXC_LATENCY       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } vxc_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/vxc_valid_pipe.sv
// Fixed-depth shift register tracking {valid, addr, last} of issued chunks
// alongside the datapath; clr_i empties every slot on the next edge.
module vxc_valid_pipe
  import vxc_pkg::*;
#(
  parameter int DEPTH  = VXC_LATENCY,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  last_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign last_o  = last_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/vxc_add_sequencer.sv
// Sequences one vector add/subtract-by-constant: issues NOE elements as NI-lane
// chunks, then tracks results through the datapath latency to a finish pulse.
module vxc_add_sequencer
  import vxc_pkg::*;
#(
  parameter int NOE           = 19,
  parameter int NI            = VXC_NI,
  parameter int LATENCY       = VXC_LATENCY,
  parameter int ELEMENT_WIDTH = VXC_ELEMENT_WIDTH,
  parameter int ADDR_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op_in,
  input  logic [ELEMENT_WIDTH-1:0] constant_in,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     dp_op,
  output logic [ELEMENT_WIDTH-1:0] dp_constant,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NI-1:0]            wr_mask,
  output logic                     finish
);

  localparam int                CHUNKS    = ceil_div(NOE, NI);
  localparam int                REM       = NOE % NI;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS - 1);
  localparam logic [NI-1:0]     FULL_MASK = {NI{1'b1}};
  // Lane 0 is the MSB, so a partial tail keeps the top REM bits.
  localparam logic [NI-1:0]     TAIL_MASK = (REM == 0) ? FULL_MASK : ~(FULL_MASK >> REM);

  vxc_state_e                 state_q;
  logic                       busy_q;
  logic                       rd_en_q;
  logic [ADDR_W-1:0]          rd_addr_q;
  logic                       dp_op_q;
  logic [ELEMENT_WIDTH-1:0]   dp_constant_q;

  logic                       pipe_valid_s;
  logic                       pipe_last_s;
  logic [ADDR_W-1:0]          pipe_addr_s;
  logic                       issue_last_s;

  assign issue_last_s = rd_en_q && (rd_addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      dp_op_q       <= 1'b0;
      dp_constant_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_ISSUE;
            busy_q        <= 1'b1;
            rd_en_q       <= 1'b1;
            rd_addr_q     <= '0;
            dp_op_q       <= op_in;
            dp_constant_q <= constant_in;
          end
        end
        ST_ISSUE: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q   <= ST_DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (pipe_valid_s && pipe_last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
        end
      endcase
    end
  end

  vxc_valid_pipe #(
    .DEPTH  (LATENCY),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk     (clk),
    .clr_i   (reset),
    .valid_i (rd_en_q),
    .addr_i  (rd_addr_q),
    .last_i  (issue_last_s),
    .valid_o (pipe_valid_s),
    .addr_o  (pipe_addr_s),
    .last_o  (pipe_last_s)
  );

  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign dp_op       = dp_op_q;
  assign dp_constant = dp_constant_q;
  assign wr_en       = pipe_valid_s;
  assign wr_addr     = pipe_valid_s ? pipe_addr_s : '0;
  assign wr_mask     = !pipe_valid_s ? '0 : (pipe_last_s ? TAIL_MASK : FULL_MASK);
  assign finish      = pipe_valid_s && pipe_last_s;

endmodule

// File: tb/tb_vxc_add_sequencer.sv
// Scoreboard bench: three sequencer instances (NOE 19, 16, 5) driven by directed
// operations; expected issue/result events are queued and a negedge monitor pops them.
module tb_vxc_add_sequencer;

  localparam int LAT = 8;

  typedef struct {
    int          dut;
    int          cyc;
    int          addr;
    int          mask;
    bit          fin;
    bit          op;
    logic [63:0] cst;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic        op_in;
  logic [63:0] cst_in;

  logic [2:0]  busy_v, rd_en_v, dp_op_v, wr_en_v, finish_v;
  logic [7:0]  rd_addr_a [3];
  logic [7:0]  wr_addr_a [3];
  logic [7:0]  wr_mask_a [3];
  logic [63:0] dpc_a [3];

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t rd_q[$];
  ev_t wr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vxc_add_sequencer #(.NOE(19)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op_in(op_in), .constant_in(cst_in),
    .busy(busy_v[0]), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_a[0]), .dp_op(dp_op_v[0]),
    .dp_constant(dpc_a[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_a[0]),
    .wr_mask(wr_mask_a[0]), .finish(finish_v[0]));

  vxc_add_sequencer #(.NOE(16)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op_in(op_in), .constant_in(cst_in),
    .busy(busy_v[1]), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_a[1]), .dp_op(dp_op_v[1]),
    .dp_constant(dpc_a[1]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_a[1]),
    .wr_mask(wr_mask_a[1]), .finish(finish_v[1]));

  vxc_add_sequencer #(.NOE(5)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op_in(op_in), .constant_in(cst_in),
    .busy(busy_v[2]), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_a[2]), .dp_op(dp_op_v[2]),
    .dp_constant(dpc_a[2]), .wr_en(wr_en_v[2]), .wr_addr(wr_addr_a[2]),
    .wr_mask(wr_mask_a[2]), .finish(finish_v[2]));

  // Monitor: every issue and result event must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    for (int g = 0; g < 3; g++) begin
      if (rd_en_v[g]) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: dut%0d cyc %0d addr %0d, required no issue", g, cyc, rd_addr_a[g]);
        end else begin
          e = rd_q.pop_front();
          if (e.dut != g || e.cyc != cyc || e.addr != int'(rd_addr_a[g])) begin
            n_bad++;
            $display("FAIL rd_event: got dut%0d cyc %0d addr %0d, required dut%0d cyc %0d addr %0d",
                     g, cyc, rd_addr_a[g], e.dut, e.cyc, e.addr);
          end
        end
      end
      if (wr_en_v[g]) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: dut%0d cyc %0d addr %0d, required no result", g, cyc, wr_addr_a[g]);
        end else begin
          e = wr_q.pop_front();
          if (e.dut != g || e.cyc != cyc || e.addr != int'(wr_addr_a[g]) ||
              e.mask != int'(wr_mask_a[g]) || e.fin != finish_v[g] ||
              e.op != dp_op_v[g] || e.cst != dpc_a[g]) begin
            n_bad++;
            $display("FAIL wr_event: got dut%0d cyc %0d addr %0d mask %h fin %0d op %0d cst %h, required dut%0d cyc %0d addr %0d mask %h fin %0d op %0d cst %h",
                     g, cyc, wr_addr_a[g], wr_mask_a[g], finish_v[g], dp_op_v[g], dpc_a[g],
                     e.dut, e.cyc, e.addr, e.mask[7:0], e.fin, e.op, e.cst);
          end
        end
      end else begin
        n_cmp++;
        if (finish_v[g] || wr_addr_a[g] != 8'h00 || wr_mask_a[g] != 8'h00) begin
          n_bad++;
          $display("FAIL wr_idle: dut%0d cyc %0d fin %0d addr %h mask %h, required all 0",
                   g, cyc, finish_v[g], wr_addr_a[g], wr_mask_a[g]);
        end
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_op(input int g, input int b, input int chunks, input int last_mask,
                         input bit op, input logic [63:0] c, input bit with_wr);
    ev_t e;
    for (int k = 0; k < chunks; k++) begin
      e.dut = g; e.addr = k; e.op = op; e.cst = c;
      e.cyc = b + 1 + k; e.mask = 0; e.fin = 1'b0;
      rd_q.push_back(e);
      if (with_wr) begin
        e.cyc  = b + 1 + LAT + k;
        e.mask = (k == chunks - 1) ? last_mask : 32'hFF;
        e.fin  = (k == chunks - 1);
        wr_q.push_back(e);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: cyc %0d got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic check_zero(input int g, input string name);
    logic [95:0] v;
    v = {busy_v[g], rd_en_v[g], rd_addr_a[g], dp_op_v[g], dpc_a[g], wr_en_v[g],
         wr_addr_a[g], wr_mask_a[g], finish_v[g]};
    n_cmp++;
    if (v !== 96'h0) begin
      n_bad++;
      $display("FAIL %s: dut%0d cyc %0d outputs %h, required 0", name, g, cyc, v);
    end
  endtask

  initial begin
    int b;
    reset = 1'b1; start_v = 3'b000; op_in = 1'b0; cst_in = 64'h0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check_zero(g, "reset_state");
    reset = 1'b0;

    // NOE=19: 3 chunks, tail mask E0; op/constant changed mid-op; re-pulsed start.
    b = cyc + 2;
    at(b);
    check_bit("busy_before_start", busy_v[0], 1'b0);
    op_in = 1'b1; cst_in = 64'h3F80000000000000; start_v[0] = 1'b1;
    push_op(0, b, 3, 32'hE0, 1'b1, 64'h3F80000000000000, 1'b1);
    at(b + 1);  start_v[0] = 1'b0;
    check_bit("busy_first", busy_v[0], 1'b1);
    at(b + 2);  op_in = 1'b0; cst_in = 64'h0;
    at(b + 4);  start_v[0] = 1'b1;
    at(b + 5);  start_v[0] = 1'b0;
    at(b + 11); start_v[0] = 1'b1;
    check_bit("busy_finish_cycle", busy_v[0], 1'b1);
    at(b + 12);
    check_bit("busy_after_finish", busy_v[0], 1'b0);
    op_in = 1'b0; cst_in = 64'h4000000040400000;
    push_op(0, b + 12, 3, 32'hE0, 1'b0, 64'h4000000040400000, 1'b1);
    at(b + 13); start_v[0] = 1'b0;
    at(b + 28);

    // NOE=16: 2 chunks, both full masks.
    b = cyc + 2;
    at(b);
    op_in = 1'b0; cst_in = 64'h40000000BF800000; start_v[1] = 1'b1;
    push_op(1, b, 2, 32'hFF, 1'b0, 64'h40000000BF800000, 1'b1);
    at(b + 1);  start_v[1] = 1'b0;
    at(b + 10);
    check_bit("busy16_finish_cycle", busy_v[1], 1'b1);
    at(b + 14);

    // NOE=5: single chunk, mask F8.
    b = cyc + 2;
    at(b);
    op_in = 1'b1; cst_in = 64'hC1200000_3F000000; start_v[2] = 1'b1;
    push_op(2, b, 1, 32'hF8, 1'b1, 64'hC1200000_3F000000, 1'b1);
    at(b + 1);  start_v[2] = 1'b0;
    at(b + 14);

    // Reset mid-operation aborts: issues happen, results never do.
    b = cyc + 2;
    at(b);
    op_in = 1'b1; cst_in = 64'h1234567800000000; start_v[0] = 1'b1;
    push_op(0, b, 3, 32'hE0, 1'b1, 64'h1234567800000000, 1'b0);
    at(b + 1);  start_v[0] = 1'b0;
    at(b + 5);  reset = 1'b1;
    at(b + 6);  reset = 1'b0;
    check_zero(0, "reset_abort");
    at(b + 21);

    // Start coincident with reset is ignored.
    at(b + 22); reset = 1'b1; start_v[2] = 1'b1;
    at(b + 23); reset = 1'b0; start_v[2] = 1'b0;
    check_bit("busy_start_in_reset", busy_v[2], 1'b0);
    at(b + 26);

    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_pending: %0d issue events outstanding, required 0", rd_q.size());
    end
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL wr_pending: %0d result events outstanding, required 0", wr_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
